// File: rtl/regfile_pkg.sv
// Shared defaults and sizing helpers for the scoreboarded register file.
package regfile_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 32;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Index 0 and anything past the last register are hardwired: never stored, never busy.
  function automatic logic idx_ok(input int idx, input int nregs);
    return (idx != 0) && (idx < nregs);
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-producer bits with set/clear/flush priority and a live popcount.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = DEF_NREGS,
  localparam int AW = clog2(NREGS),
  localparam int CW = clog2(NREGS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_addr,
  input  logic             flush,
  output logic [NREGS-1:0] busy,
  output logic [CW-1:0]    busy_cnt
);

  logic [NREGS-1:0] busy_next;
  logic [CW-1:0]    cnt_next;

  // Clear first so a same-index issue wins; flush overrides any issue.
  always_comb begin
    busy_next = busy;
    if (wr_en && idx_ok(int'(wr_addr), NREGS))
      busy_next[wr_addr] = 1'b0;
    if (flush)
      busy_next = '0;
    else if (iss_en && idx_ok(int'(iss_addr), NREGS))
      busy_next[iss_addr] = 1'b1;
  end

  always_comb begin
    cnt_next = '0;
    for (int i = 0; i < NREGS; i++)
      cnt_next = cnt_next + CW'(busy_next[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_next;
      busy_cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with write-to-read bypass and an operand scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int NREGS = DEF_NREGS,
  parameter int NRD   = 2,
  localparam int AW = clog2(NREGS),
  localparam int CW = clog2(NREGS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  input  logic                flush,
  output logic [CW-1:0]       busy_cnt
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else if (wr_en && idx_ok(int'(wr_addr), NREGS)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  rf_scoreboard #(.NREGS(NREGS)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .flush    (flush),
    .busy     (busy),
    .busy_cnt (busy_cnt)
  );

  // A same-cycle writeback both forwards its data and retires the busy mark.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] a;
    logic          ok;
    logic          hit;

    assign a   = rd_addr[k*AW +: AW];
    assign ok  = idx_ok(int'(a), NREGS);
    assign hit = ok && wr_en && (wr_addr == a);

    assign rd_data[k*XLEN +: XLEN] = !ok ? '0 : (hit ? wr_data : regs[a]);
    assign rd_busy[k]              = ok && busy[a] && !hit;
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning register width in bits.
REQ-002 SHALL have parameter NREGS, default 32, meaning number of architectural registers (>=2).
REQ-003 SHALL have parameter NRD, default 2, meaning number of read ports (>=1).
REQ-004 SHALL derive localparam AW = clog2(NREGS) and CW = clog2(NREGS+1).
REQ-005 SHALL have port: clk  input  1  rising-edge clock.
REQ-006 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port: rd_addr  input  NRD*AW  packed read addresses; port k at bits [k*AW +: AW].
REQ-008 SHALL have port: rd_data  output  NRD*XLEN  packed read data, port k at [k*XLEN +: XLEN].
REQ-009 SHALL have port: rd_busy  output  NRD  per-port "operand not yet written" flag.
REQ-010 SHALL have port: wr_en  input  1  writeback strobe.
REQ-011 SHALL have port: wr_addr  input  AW  writeback register index.
REQ-012 SHALL have port: wr_data  input  XLEN  writeback value.
REQ-013 SHALL have port: iss_en  input  1  issue strobe; marks iss_addr as pending producer.
REQ-014 SHALL have port: iss_addr  input  AW  destination of issued instruction.
REQ-015 SHALL have port: flush  input  1  clears all pending marks.
REQ-016 SHALL have port: busy_cnt  output  CW  number of registers currently marked busy.

Function
REQ-017 SHALL update register storage on rising clk edge only (no negedge write).
REQ-018 SHALL read combinationally: rd_data[k] = reg[rd_addr[k]].
REQ-019 SHALL hardwire index 0: reads return 0, rd_busy 0; writes and issues to 0 ignored.
REQ-020 SHALL treat any index >= NREGS like index 0 (read 0, not busy, write/issue ignored).
REQ-021 SHALL bypass: when wr_en and wr_addr==rd_addr[k]!=0, rd_data[k]=wr_data in the same cycle.
REQ-022 SHALL drive rd_busy[k] = busy[rd_addr[k]] AND NOT (wr_en AND wr_addr==rd_addr[k]).
REQ-023 SHALL not let same-cycle iss_en affect rd_busy; issue takes effect from next cycle.
REQ-024 SHALL clear busy[wr_addr] on clk edge when wr_en.
REQ-025 SHALL set busy[iss_addr] on clk edge when iss_en and not flush.
REQ-026 SHALL give set priority when iss_en and wr_en target the same index same cycle (busy stays 1, data written).
REQ-027 SHALL on flush clear all busy bits at clk edge, ignoring same-cycle iss_en; wr_en data write still performed.
REQ-028 SHALL register busy_cnt as popcount of next busy vector, i.e. busy_cnt always equals popcount(busy) with zero extra latency.
REQ-029 SHALL give all read ports identical, independent behaviour; any ports may alias the same index.
REQ-030 SHALL accept iss_en to an already-busy index without error (bit remains 1, count unchanged).

Reset
REQ-031 SHALL on rst asserted asynchronously clear all registers to 0, all busy bits to 0, busy_cnt to 0.
REQ-032 SHALL ignore wr_en, iss_en, flush while rst is high; first update at first rising edge after deassertion.
REQ-033 SHALL make rd_data 0 and rd_busy 0 for all ports during reset (bypass still applies if wr_en high, combinational).

Structure
REQ-034 SHALL place XLEN/NREGS defaults and the AW/CW clog2 helper in shared package regfile_pkg.
REQ-035 SHALL implement busy vector, set/clear/flush priority and busy_cnt in sub-module rf_scoreboard; storage and read/bypass muxes stay in regfile_sb.

Verification
REQ-036 Reset then read x5 on both ports -> rd_data 0, rd_busy 0, busy_cnt 0.
REQ-037 wr_en=1 wr_addr=5 wr_data=0xDEADBEEF, rd_addr[0]=5 same cycle -> rd_data[0]=0xDEADBEEF immediately and after edge.
REQ-038 Write 0x1234 to x0 -> reads of x0 stay 0; iss_en to x0 -> busy_cnt stays 0.
REQ-039 iss x7 (cycle 1), read x7 cycle 2 -> rd_busy=1, busy_cnt=1; wr x7=0x55 cycle 3 -> same-cycle rd_busy=0, rd_data=0x55, busy_cnt=0 after edge.
REQ-040 iss x3 and wr x3 same cycle -> busy[3]=1 next cycle, reg x3 holds written value; iss x4+flush same cycle with x3,x9 busy -> busy_cnt=0.
REQ-041 Assert rst mid-sequence with busy_cnt=3 and x2=0xA5 -> immediately busy_cnt=0, x2 reads 0, no clock required.
